// File: rtl/rx_dll_packet_buffer.sv
// Store-and-forward RX beat buffer between the deframer and the DLL; a packet becomes visible only once its end beat commits.
// Read head is combinational from mem[rd_ptr]; the PHY side cannot be stalled, so lost beats are reported and the packet is rolled back.
module rx_dll_packet_buffer #(
  parameter int DATA_WIDTH       = 256,
  parameter int BUFFER_DEPTH     = 16,
  parameter int ADDR_WIDTH       = 4,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5
) (
  input  logic                        CLK,
  input  logic                        RST_L,
  input  logic                        Soft_RST_blocks,
  input  logic                        i_WR_EN,
  input  logic [0:DATA_WIDTH-1]       Data_IN,
  input  logic                        i_SOP,
  input  logic                        i_End_Valid,
  input  logic                        i_Type,
  input  logic [PACKET_LENGTH-1:0]    i_Length,
  input  logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte,
  input  logic                        i_Nullify,
  input  logic                        i_RD_EN,
  output logic [0:DATA_WIDTH-1]       Data_Out,
  output logic                        o_SOP,
  output logic                        o_End_Valid,
  output logic                        o_Type,
  output logic [PACKET_LENGTH-1:0]    o_Length,
  output logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte,
  output logic                        o_Empty,
  output logic [ADDR_WIDTH:0]         o_Pkt_Count,
  output logic                        o_Pkt_Drop,
  output logic                        o_Overflow,
  output logic                        o_Protocol_Err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       data;
    logic [SYMBOL_PTR_WIDTH-1:0] last_byte;
    logic [PACKET_LENGTH-1:0]    length;
    logic                        sop;
    logic                        end_valid;
    logic                        pkt_type;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] wr_nxt, cmt_nxt, base;
  entry_t              mem [BUFFER_DEPTH];
  entry_t              head, wr_entry;
  logic                full, we, commit, pop, pop_eop;
  logic                drop_nxt, ovf_nxt, perr_nxt;

  function automatic logic is_full(input logic [ADDR_WIDTH:0] w, input logic [ADDR_WIDTH:0] r);
    return (w[ADDR_WIDTH] != r[ADDR_WIDTH]) && (w[ADDR_WIDTH-1:0] == r[ADDR_WIDTH-1:0]);
  endfunction

  always_comb begin
    wr_entry.data      = Data_IN;
    wr_entry.last_byte = i_Last_Byte;
    wr_entry.length    = i_Length;
    wr_entry.sop       = i_SOP;
    wr_entry.end_valid = i_End_Valid;
    wr_entry.pkt_type  = i_Type;
  end

  always_comb begin
    // A new SOP always restarts at the committed pointer, discarding any open packet.
    base      = (state != IDLE && i_SOP) ? cmt_ptr : wr_ptr;
    full      = is_full(base, rd_ptr);
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cmt_nxt   = cmt_ptr;
    we        = 1'b0;
    commit    = 1'b0;
    drop_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    perr_nxt  = 1'b0;
    if (i_WR_EN) begin
      if (i_SOP) begin
        perr_nxt  = (state != IDLE);
        drop_nxt  = (state != IDLE);
        wr_nxt    = base;
        state_nxt = IDLE;
        if (full) begin
          ovf_nxt = 1'b1;
          if (i_End_Valid) drop_nxt  = 1'b1;
          else             state_nxt = DROP;
        end else if (i_End_Valid) begin
          if (i_Nullify) begin
            drop_nxt = 1'b1;
          end else begin
            we      = 1'b1;
            commit  = 1'b1;
            wr_nxt  = base + PTR_ONE;
            cmt_nxt = base + PTR_ONE;
          end
        end else begin
          we        = 1'b1;
          wr_nxt    = base + PTR_ONE;
          state_nxt = RECV;
        end
      end else begin
        case (state)
          IDLE: perr_nxt = 1'b1;
          RECV: begin
            if (i_End_Valid && i_Nullify) begin
              drop_nxt  = 1'b1;
              wr_nxt    = cmt_ptr;
              state_nxt = IDLE;
            end else if (full) begin
              ovf_nxt = 1'b1;
              if (i_End_Valid) begin
                drop_nxt  = 1'b1;
                wr_nxt    = cmt_ptr;
                state_nxt = IDLE;
              end else begin
                state_nxt = DROP;
              end
            end else begin
              we     = 1'b1;
              wr_nxt = wr_ptr + PTR_ONE;
              if (i_End_Valid) begin
                commit    = 1'b1;
                cmt_nxt   = wr_ptr + PTR_ONE;
                state_nxt = IDLE;
              end
            end
          end
          DROP: begin
            ovf_nxt = 1'b1;
            if (i_End_Valid) begin
              drop_nxt  = 1'b1;
              wr_nxt    = cmt_ptr;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign o_Empty = (cmt_ptr == rd_ptr);
  assign pop     = i_RD_EN && !o_Empty;
  assign pop_eop = pop && head.end_valid;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      cmt_ptr        <= '0;
      rd_ptr         <= '0;
      o_Pkt_Count    <= '0;
      o_Pkt_Drop     <= 1'b0;
      o_Overflow     <= 1'b0;
      o_Protocol_Err <= 1'b0;
    end else if (Soft_RST_blocks) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      cmt_ptr        <= '0;
      rd_ptr         <= '0;
      o_Pkt_Count    <= '0;
      o_Pkt_Drop     <= 1'b0;
      o_Overflow     <= 1'b0;
      o_Protocol_Err <= 1'b0;
    end else begin
      state          <= state_nxt;
      wr_ptr         <= wr_nxt;
      cmt_ptr        <= cmt_nxt;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (commit && !pop_eop)      o_Pkt_Count <= o_Pkt_Count + PTR_ONE;
      else if (!commit && pop_eop) o_Pkt_Count <= o_Pkt_Count - PTR_ONE;
      o_Pkt_Drop     <= drop_nxt;
      o_Overflow     <= ovf_nxt;
      o_Protocol_Err <= perr_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
    end else if (Soft_RST_blocks) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[base[ADDR_WIDTH-1:0]] <= wr_entry;
    end
  end

  assign Data_Out    = head.data;
  assign o_SOP       = head.sop;
  assign o_End_Valid = head.end_valid;
  assign o_Type      = head.pkt_type;
  assign o_Length    = head.length;
  assign o_Last_Byte = head.last_byte;

endmodule

// File: tb/tb_rx_dll_packet_buffer.sv
// Directed bench for rx_dll_packet_buffer: vector table for simple sequences, hand-written sequences for fill, same-cycle and soft-reset cases.
module tb_rx_dll_packet_buffer;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic         CLK = 1'b0;
  logic         RST_L = 1'b0;
  logic         Soft_RST_blocks = 1'b0;
  logic         i_WR_EN = 1'b0;
  logic [0:255] Data_IN = '0;
  logic         i_SOP = 1'b0, i_End_Valid = 1'b0, i_Type = 1'b0;
  logic [10:0]  i_Length = '0;
  logic [4:0]   i_Last_Byte = '0;
  logic         i_Nullify = 1'b0, i_RD_EN = 1'b0;
  logic [0:255] Data_Out;
  logic         o_SOP, o_End_Valid, o_Type;
  logic [10:0]  o_Length;
  logic [4:0]   o_Last_Byte;
  logic         o_Empty;
  logic [4:0]   o_Pkt_Count;
  logic         o_Pkt_Drop, o_Overflow, o_Protocol_Err;

  int n_cmp = 0;
  int n_err = 0;

  rx_dll_packet_buffer dut (
    .CLK(CLK), .RST_L(RST_L), .Soft_RST_blocks(Soft_RST_blocks), .i_WR_EN(i_WR_EN),
    .Data_IN(Data_IN), .i_SOP(i_SOP), .i_End_Valid(i_End_Valid), .i_Type(i_Type),
    .i_Length(i_Length), .i_Last_Byte(i_Last_Byte), .i_Nullify(i_Nullify), .i_RD_EN(i_RD_EN),
    .Data_Out(Data_Out), .o_SOP(o_SOP), .o_End_Valid(o_End_Valid), .o_Type(o_Type),
    .o_Length(o_Length), .o_Last_Byte(o_Last_Byte), .o_Empty(o_Empty), .o_Pkt_Count(o_Pkt_Count),
    .o_Pkt_Drop(o_Pkt_Drop), .o_Overflow(o_Overflow), .o_Protocol_Err(o_Protocol_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr, sop, eop, nul, typ;
    logic [4:0]  lb;
    logic [31:0] tag;
    logic        rd;
    logic        e_empty;
    logic [4:0]  e_cnt;
    logic        e_drop, e_ovf, e_perr;
    logic        hd;
    logic [31:0] e_tag;
    logic        e_sop, e_eop;
    logic [4:0]  e_lb;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [255:0] pat(input logic [31:0] t);
    return {8{t}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic sop, input logic eop, input logic nul,
                       input logic typ, input logic [4:0] lb, input logic [31:0] tag, input logic rd);
    i_WR_EN     = wr;
    i_SOP       = sop;
    i_End_Valid = eop;
    i_Nullify   = nul;
    i_Type      = typ;
    i_Last_Byte = lb;
    i_Length    = tag[10:0];
    Data_IN     = pat(tag);
    i_RD_EN     = rd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(L, L, L, L, L, 5'd0, 32'd0, L);
  endtask

  task automatic chk_head(input string name, input logic [31:0] tag, input logic sop, input logic eop);
    chk({name, "_data"}, Data_Out, pat(tag));
    chk({name, "_len"}, {245'd0, o_Length}, {245'd0, tag[10:0]});
    chk({name, "_sop"}, {255'd0, o_SOP}, {255'd0, sop});
    chk({name, "_eop"}, {255'd0, o_End_Valid}, {255'd0, eop});
  endtask

  task automatic chk_state(input string name, input logic empty, input logic [4:0] cnt);
    chk({name, "_empty"}, {255'd0, o_Empty}, {255'd0, empty});
    chk({name, "_cnt"}, {251'd0, o_Pkt_Count}, {251'd0, cnt});
  endtask

  initial begin
    // Packet A: 3-beat TLP, then popped out.
    vecs[0]  = '{H,H,L,L,H,5'd0,32'hA1,L, H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    vecs[1]  = '{H,L,L,L,H,5'd0,32'hA2,L, H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    vecs[2]  = '{H,L,H,L,H,5'd7,32'hA3,L, L,5'd1,L,L,L, H,32'hA1,H,L,5'd0};
    vecs[3]  = '{L,L,L,L,L,5'd0,32'h0,H,  L,5'd1,L,L,L, H,32'hA2,L,L,5'd0};
    vecs[4]  = '{L,L,L,L,L,5'd0,32'h0,H,  L,5'd1,L,L,L, H,32'hA3,L,H,5'd7};
    vecs[5]  = '{L,L,L,L,L,5'd0,32'h0,H,  H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    vecs[6]  = '{L,L,L,L,L,5'd0,32'h0,H,  H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    // Packet B: nullified on its end beat.
    vecs[7]  = '{H,H,L,L,H,5'd0,32'hB1,L, H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    vecs[8]  = '{H,L,H,H,H,5'd2,32'hB2,L, H,5'd0,H,L,L, L,32'h0,L,L,5'd0};
    vecs[9]  = '{L,L,L,L,L,5'd0,32'h0,L,  H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    // Packet C loses its EOP to a new SOP; packet D commits in C's place.
    vecs[10] = '{H,H,L,L,H,5'd0,32'hC1,L, H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    vecs[11] = '{H,L,L,L,H,5'd0,32'hC2,L, H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    vecs[12] = '{H,H,L,L,H,5'd0,32'hD1,L, H,5'd0,H,L,H, L,32'h0,L,L,5'd0};
    vecs[13] = '{H,L,H,L,H,5'd3,32'hD2,L, L,5'd1,L,L,L, H,32'hD1,H,L,5'd0};
    vecs[14] = '{L,L,L,L,L,5'd0,32'h0,H,  L,5'd1,L,L,L, H,32'hD2,L,H,5'd3};
    vecs[15] = '{L,L,L,L,L,5'd0,32'h0,H,  H,5'd0,L,L,L, L,32'h0,L,L,5'd0};
    // Mid-packet beat with no open packet.
    vecs[16] = '{H,L,L,L,H,5'd0,32'hE1,L, H,5'd0,L,L,H, L,32'h0,L,L,5'd0};
    vecs[17] = '{L,L,L,L,L,5'd0,32'h0,L,  H,5'd0,L,L,L, L,32'h0,L,L,5'd0};

    idle();
    repeat (3) @(posedge CLK);
    #1;
    chk_state("rst", H, 5'd0);
    chk("rst_drop", {255'd0, o_Pkt_Drop}, 256'd0);
    chk("rst_ovf", {255'd0, o_Overflow}, 256'd0);
    chk("rst_perr", {255'd0, o_Protocol_Err}, 256'd0);
    chk("rst_head", Data_Out, 256'd0);
    chk("rst_sop", {255'd0, o_SOP}, 256'd0);
    @(negedge CLK);
    RST_L = 1'b1;
    step();

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].wr, vecs[v].sop, vecs[v].eop, vecs[v].nul, vecs[v].typ, vecs[v].lb, vecs[v].tag, vecs[v].rd);
      step();
      chk_state($sformatf("v%0d", v), vecs[v].e_empty, vecs[v].e_cnt);
      chk($sformatf("v%0d_drop", v), {255'd0, o_Pkt_Drop}, {255'd0, vecs[v].e_drop});
      chk($sformatf("v%0d_ovf", v), {255'd0, o_Overflow}, {255'd0, vecs[v].e_ovf});
      chk($sformatf("v%0d_perr", v), {255'd0, o_Protocol_Err}, {255'd0, vecs[v].e_perr});
      if (vecs[v].hd) begin
        chk_head($sformatf("v%0d", v), vecs[v].e_tag, vecs[v].e_sop, vecs[v].e_eop);
        chk($sformatf("v%0d_lb", v), {251'd0, o_Last_Byte}, {251'd0, vecs[v].e_lb});
      end
    end

    // Single-beat DLLP committed while the previous packet's end beat is popped.
    drive(H, H, L, L, H, 5'd0, 32'h51, L); step();
    drive(H, L, H, L, H, 5'd4, 32'h52, L); step();
    chk_state("p5_commit", L, 5'd1);
    chk_head("p5_h1", 32'h51, H, L);
    drive(L, L, L, L, L, 5'd0, 32'h0, H); step();
    chk_head("p5_h2", 32'h52, L, H);
    drive(H, H, H, L, L, 5'd9, 32'h5D, H); step();
    chk_state("p5_same", L, 5'd1);
    chk_head("p5_dllp", 32'h5D, H, H);
    chk("p5_type", {255'd0, o_Type}, 256'd0);
    chk("p5_lb", {251'd0, o_Last_Byte}, {251'd0, 5'd9});
    drive(L, L, L, L, L, 5'd0, 32'h0, H); step();
    chk_state("p5_drain", H, 5'd0);

    // Fill 14 beats as two packets, then overflow a 4-beat packet.
    for (int i = 0; i < 14; i++) begin
      drive(H, (i == 0 || i == 7), (i == 6 || i == 13), L, H, 5'd0, 32'h300 + i, L);
      step();
    end
    chk_state("p3_fill", L, 5'd2);
    for (int k = 0; k < 4; k++) begin
      drive(H, (k == 0), (k == 3), L, H, 5'd1, 32'h400 + k, L);
      step();
      chk($sformatf("p3_ovf%0d", k), {255'd0, o_Overflow}, {255'd0, (k >= 2)});
      chk($sformatf("p3_drop%0d", k), {255'd0, o_Pkt_Drop}, {255'd0, (k == 3)});
    end
    idle(); step();
    chk("p3_ovf_end", {255'd0, o_Overflow}, 256'd0);
    chk("p3_drop_end", {255'd0, o_Pkt_Drop}, 256'd0);
    chk_state("p3_after", L, 5'd2);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("p3_rd%0d", i), Data_Out, pat(32'h300 + i));
      drive(L, L, L, L, L, 5'd0, 32'h0, H); step();
      if (i == 6) chk_state("p3_half", L, 5'd1);
    end
    chk_state("p3_drained", H, 5'd0);

    // Soft reset in the middle of a packet, with one committed packet pending.
    drive(H, H, H, L, H, 5'd0, 32'h61, L); step();
    drive(H, H, L, L, H, 5'd0, 32'h62, L); step();
    drive(H, L, L, L, H, 5'd0, 32'h63, L); step();
    chk_state("p6_pre", L, 5'd1);
    idle();
    Soft_RST_blocks = 1'b1; step();
    Soft_RST_blocks = 1'b0;
    chk_state("p6_srst", H, 5'd0);
    chk("p6_head", Data_Out, 256'd0);
    drive(H, H, L, L, H, 5'd0, 32'h71, L); step();
    chk("p6_perr", {255'd0, o_Protocol_Err}, 256'd0);
    chk_state("p6_open", H, 5'd0);
    drive(H, L, H, L, H, 5'd5, 32'h72, L); step();
    chk_state("p6_commit", L, 5'd1);
    chk_head("p6_h1", 32'h71, H, L);
    drive(L, L, L, L, L, 5'd0, 32'h0, H); step();
    chk_head("p6_h2", 32'h72, L, H);
    drive(L, L, L, L, L, 5'd0, 32'h0, H); step();
    chk_state("p6_drain", H, 5'd0);
    idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
